// File: rtl/const_div_pipe_if.sv
// rtl/const_div_pipe_if.sv - operand/result stream bundle for const_div_pipe
// Purpose: groups the operand input stream and the result output stream.
// Ports (signals):
//   in_valid/in_ready/in_x/in_tag        operand stream, producer -> divider
//   out_valid/out_ready/out_q/out_r/out_tag result stream, divider -> consumer
// Modports: slave = divider side, master = producer/consumer side.
interface const_div_pipe_if #(
   parameter int WIDTH   = 64,
   parameter int DIVISOR = 3,
   parameter int TAG_W   = 4
);
   localparam int RW = (DIVISOR <= 2) ? 1 : $clog2(DIVISOR);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_x;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_q;
   logic [RW-1:0]    out_r;
   logic [TAG_W-1:0] out_tag;

   modport slave (
      input  in_valid, in_x, in_tag, out_ready,
      output in_ready, out_valid, out_q, out_r, out_tag
   );

   modport master (
      output in_valid, in_x, in_tag, out_ready,
      input  in_ready, out_valid, out_q, out_r, out_tag
   );
endinterface

// File: rtl/const_div_pipe.sv
// rtl/const_div_pipe.sv - pipelined unsigned divider by a compile-time constant
// Purpose: quotient and remainder of an unsigned WIDTH-bit operand divided by
//   DIVISOR, retiring CHUNK dividend bits per stage, one result per clock.
// Ports:
//   clk     clock
//   rst_n   asynchronous active-low reset
//   io      const_div_pipe_if.slave: operand stream (in_*) and result stream
//           (out_*), valid/ready handshakes, tag returned with each result
module const_div_pipe #(
   parameter int WIDTH   = 64,
   parameter int DIVISOR = 3,
   parameter int CHUNK   = 8,
   parameter int TAG_W   = 4
) (
   input  logic clk,
   input  logic rst_n,
   const_div_pipe_if.slave io
);
   localparam int NSTAGE = WIDTH / CHUNK;
   localparam int RW     = (DIVISOR <= 2) ? 1 : $clog2(DIVISOR);

   // Restoring long division of one chunk by the constant divisor. The
   // running remainder is always < DIVISOR, so after each shift-in it is
   // < 2*DIVISOR and needs only one conditional constant subtraction.
   function automatic logic [CHUNK+RW-1:0] div_step(
      input logic [RW-1:0]    r_in,
      input logic [CHUNK-1:0] c
   );
      logic [RW:0]      r;
      logic [CHUNK-1:0] d;
      r = {1'b0, r_in};
      d = '0;
      for (int i = CHUNK - 1; i >= 0; i--) begin
         r = {r[RW-1:0], c[i]};
         if (r >= (RW+1)'(DIVISOR)) begin
            r    = r - (RW+1)'(DIVISOR);
            d[i] = 1'b1;
         end
      end
      return {d, r[RW-1:0]};
   endfunction

   logic [NSTAGE:0]  v;
   logic [NSTAGE:0]  adv;
   logic [WIDTH-1:0] x_r [0:NSTAGE-1];   // dividend bits not yet consumed, MSB-aligned
   logic [WIDTH-1:0] q_r [1:NSTAGE];     // quotient bits produced so far
   logic [RW-1:0]    r_r [1:NSTAGE];
   logic [TAG_W-1:0] t_r [0:NSTAGE];
   logic [CHUNK-1:0] dig [1:NSTAGE];
   logic [RW-1:0]    rem [1:NSTAGE];

   // A stage advances when it or any stage downstream is empty, or the
   // consumer takes the result; this is the unrolled form of
   // adv[k] = !v[k] || adv[k+1], which keeps the chain free of feedback.
   for (genvar g = 0; g <= NSTAGE; g++) begin : g_adv
      assign adv[g] = ~(&v[NSTAGE:g]) | io.out_ready;
   end

   for (genvar g = 1; g <= NSTAGE; g++) begin : g_stage
      logic [RW-1:0] r_prev;
      if (g == 1) begin : g_first
         assign r_prev = '0;
      end else begin : g_rest
         assign r_prev = r_r[g-1];
      end
      assign {dig[g], rem[g]} = div_step(r_prev, x_r[g-1][WIDTH-1 -: CHUNK]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v <= '0;
         for (int k = 0; k < NSTAGE; k++) x_r[k] <= '0;
         for (int k = 1; k <= NSTAGE; k++) begin
            q_r[k] <= '0;
            r_r[k] <= '0;
         end
         for (int k = 0; k <= NSTAGE; k++) t_r[k] <= '0;
      end else begin
         if (adv[0]) begin
            v[0] <= io.in_valid;
            if (io.in_valid) begin
               x_r[0] <= io.in_x;
               t_r[0] <= io.in_tag;
            end
         end
         if (adv[1]) begin
            v[1] <= v[0];
            if (v[0]) begin
               q_r[1] <= WIDTH'(dig[1]);
               r_r[1] <= rem[1];
               t_r[1] <= t_r[0];
            end
         end
         for (int k = 2; k <= NSTAGE; k++) begin
            if (adv[k]) begin
               v[k] <= v[k-1];
               if (v[k-1]) begin
                  q_r[k] <= (q_r[k-1] << CHUNK) | WIDTH'(dig[k]);
                  r_r[k] <= rem[k];
                  t_r[k] <= t_r[k-1];
               end
            end
         end
         for (int k = 1; k < NSTAGE; k++) begin
            if (adv[k] && v[k-1]) x_r[k] <= x_r[k-1] << CHUNK;
         end
      end
   end

   assign io.in_ready  = adv[0];
   assign io.out_valid = v[NSTAGE];
   assign io.out_q     = q_r[NSTAGE];
   assign io.out_r     = r_r[NSTAGE];
   assign io.out_tag   = t_r[NSTAGE];
endmodule

// File: tb/tb_const_div_pipe.sv
// tb/tb_const_div_pipe.sv - scoreboard bench for const_div_pipe
module tb_const_div_pipe;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   const_div_pipe_if #(.WIDTH(64), .DIVISOR(3), .TAG_W(4)) a_if ();
   const_div_pipe #(.WIDTH(64), .DIVISOR(3), .CHUNK(8), .TAG_W(4)) u_a (
      .clk(clk), .rst_n(rst_n), .io(a_if));

   const_div_pipe_if #(.WIDTH(32), .DIVISOR(7), .TAG_W(4)) b_if ();
   const_div_pipe #(.WIDTH(32), .DIVISOR(7), .CHUNK(4), .TAG_W(4)) u_b (
      .clk(clk), .rst_n(rst_n), .io(b_if));

   typedef struct {
      logic [63:0] q;
      logic [63:0] r;
      logic [3:0]  tag;
   } exp_t;

   exp_t sb_a[$];
   exp_t sb_b[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
   endtask

   // Scoreboards: compare outputs first, then record newly accepted operands.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (a_if.out_valid) begin
            if (sb_a.size() == 0) begin
               check("a_spurious_out", 64'(a_if.out_valid), 64'd0);
            end else if (a_if.out_ready) begin
               e = sb_a.pop_front();
               check("a_q", a_if.out_q, e.q);
               check("a_r", 64'(a_if.out_r), e.r);
               check("a_tag", 64'(a_if.out_tag), 64'(e.tag));
            end else begin
               check("a_hold_q", a_if.out_q, sb_a[0].q);
               check("a_hold_tag", 64'(a_if.out_tag), 64'(sb_a[0].tag));
            end
         end
         if (a_if.in_valid && a_if.in_ready)
            sb_a.push_back('{q: a_if.in_x / 64'd3, r: a_if.in_x % 64'd3, tag: a_if.in_tag});
         if (b_if.out_valid) begin
            if (sb_b.size() == 0) begin
               check("b_spurious_out", 64'(b_if.out_valid), 64'd0);
            end else if (b_if.out_ready) begin
               e = sb_b.pop_front();
               check("b_q", 64'(b_if.out_q), e.q);
               check("b_r", 64'(b_if.out_r), e.r);
               check("b_tag", 64'(b_if.out_tag), 64'(e.tag));
            end
         end
         if (b_if.in_valid && b_if.in_ready)
            sb_b.push_back('{q: 64'(b_if.in_x / 32'd7), r: 64'(b_if.in_x % 32'd7), tag: b_if.in_tag});
      end
   end

   task automatic send_a(input logic [63:0] x, input logic [3:0] tag, output int cycles);
      bit acc;
      cycles = 0;
      a_if.in_valid = 1'b1;
      a_if.in_x     = x;
      a_if.in_tag   = tag;
      do begin
         @(negedge clk);
         acc = a_if.in_ready;
         @(posedge clk);
         #1;
         cycles++;
      end while (!acc && cycles < 200);
      if (!acc) check("a_send_timeout", 64'(acc), 64'd1);
   endtask

   task automatic send_b(input logic [31:0] x, input logic [3:0] tag);
      bit acc;
      int n = 0;
      b_if.in_valid = 1'b1;
      b_if.in_x     = x;
      b_if.in_tag   = tag;
      do begin
         @(negedge clk);
         acc = b_if.in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 200);
      if (!acc) check("b_send_timeout", 64'(acc), 64'd1);
   endtask

   task automatic drain_a(input string name);
      int n = 0;
      while (sb_a.size() != 0 && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      check(name, 64'(sb_a.size()), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int cyc;
      int stalls;
      int lat;
      int acc_cnt;
      bit acc;
      int n;

      rst_n = 1'b0;
      a_if.in_valid = 1'b0; a_if.in_x = '0; a_if.in_tag = '0; a_if.out_ready = 1'b1;
      b_if.in_valid = 1'b0; b_if.in_x = '0; b_if.in_tag = '0; b_if.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(a_if.out_valid), 64'd0);
      check("rst_out_q", a_if.out_q, 64'd0);
      check("rst_out_r", 64'(a_if.out_r), 64'd0);
      check("rst_out_tag", 64'(a_if.out_tag), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_in_ready", 64'(a_if.in_ready), 64'd1);

      // Single operand, latency and value.
      send_a(64'd100, 4'd5, cyc);
      a_if.in_valid = 1'b0;
      lat = 0;
      while (!a_if.out_valid && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("t1_latency", 64'(lat), 64'd8);
      check("t1_q", a_if.out_q, 64'd33);
      check("t1_r", 64'(a_if.out_r), 64'd1);
      check("t1_tag", 64'(a_if.out_tag), 64'd5);
      drain_a("t1_drain");

      // All-ones then zero, back to back.
      send_a(64'hFFFF_FFFF_FFFF_FFFF, 4'd1, cyc);
      send_a(64'd0, 4'd2, cyc);
      a_if.in_valid = 1'b0;
      drain_a("t2_drain");

      // 100 random operands streamed with no backpressure.
      stalls = 0;
      for (int i = 0; i < 100; i++) begin
         send_a({$urandom, $urandom}, 4'($urandom), cyc);
         stalls += cyc - 1;
      end
      a_if.in_valid = 1'b0;
      check("t3_in_ready_stalls", 64'(stalls), 64'd0);
      drain_a("t3_drain");

      // Consumer stalls for 20 cycles while the producer keeps offering.
      a_if.out_ready = 1'b0;
      acc_cnt = 0;
      a_if.in_valid = 1'b1;
      a_if.in_x = {$urandom, $urandom};
      a_if.in_tag = 4'($urandom);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         acc = a_if.in_ready;
         if (acc) acc_cnt++;
         @(posedge clk);
         #1;
         if (acc) begin
            a_if.in_x = {$urandom, $urandom};
            a_if.in_tag = 4'($urandom);
         end
      end
      check("t4_accepted", 64'(acc_cnt), 64'd9);
      check("t4_in_ready_low", 64'(a_if.in_ready), 64'd0);
      a_if.in_valid = 1'b0;
      a_if.out_ready = 1'b1;
      drain_a("t4_drain");

      // Reset with five operands in flight.
      for (int i = 0; i < 5; i++) send_a({$urandom, $urandom}, 4'(i + 8), cyc);
      a_if.in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("t5_rst_out_valid", 64'(a_if.out_valid), 64'd0);
      check("t5_rst_out_q", a_if.out_q, 64'd0);
      check("t5_rst_out_r", 64'(a_if.out_r), 64'd0);
      check("t5_rst_out_tag", 64'(a_if.out_tag), 64'd0);
      sb_a.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("t5_in_ready", 64'(a_if.in_ready), 64'd1);

      // 32-bit / 7 with 4-bit chunks.
      send_b(32'hFFFF_FFFF, 4'd3);
      send_b(32'd6, 4'd4);
      for (int i = 0; i < 10; i++) send_b($urandom, 4'($urandom));
      b_if.in_valid = 1'b0;
      n = 0;
      while (sb_b.size() != 0 && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("t6_drain", 64'(sb_b.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
